// File: rtl/ahblite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahblite_pkg
// Description : Shared AHB-Lite encodings, register map and FSM state type
//               for the stream port.
// Revision    : 1.0 - initial release
// ============================================================================
package ahblite_pkg;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    localparam logic [2:0] c_hsize_word = 3'b010;

    localparam logic [1:0] c_reg_data   = 2'd0;
    localparam logic [1:0] c_reg_status = 2'd1;
    localparam logic [1:0] c_reg_ctrl   = 2'd2;

    localparam logic c_hresp_okay  = 1'b0;
    localparam logic c_hresp_error = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with flush; count, full and empty are
//               derived from registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Flush dominates any push or pop on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush)
            r_mem[r_wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/ahblite_stream_port.sv
`default_nettype none
// ============================================================================
// Module      : ahblite_stream_port
// Description : AHB-Lite responder bridging word accesses to a TX and an RX
//               32-bit valid/ready stream, with bounded wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module ahblite_stream_port
    import ahblite_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WAIT_MAX = 255
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] rx_data
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) + 1 : 1;

    state_t          r_state;
    logic [1:0]      r_offset;
    logic            r_write;
    logic [WW-1:0]   r_wait_cnt;

    logic            w_accept;
    logic            w_legal;
    logic            w_data_ok;
    logic            w_complete;
    logic            w_stall;
    logic            w_timeout;
    logic            w_can_accept;
    state_t          w_addr_state;
    logic [31:0]     w_status;
    logic            w_unused;

    logic            w_tx_push, w_tx_pop, w_tx_flush, w_tx_full, w_tx_empty;
    logic            w_rx_push, w_rx_pop, w_rx_flush, w_rx_full, w_rx_empty;
    logic [CW-1:0]   w_tx_count, w_rx_count;
    logic [31:0]     w_rx_head;

    assign w_unused = ^{HADDR[31:4], HADDR[1:0], HTRANS[0]};

    assign w_accept     = HSEL & HREADY & HTRANS[1];
    assign w_legal      = (HSIZE == c_hsize_word) && (HADDR[3:2] != 2'b11);
    assign w_addr_state = !w_accept ? ST_IDLE : (w_legal ? ST_DATA : ST_ERR1);

    // Only DATA-register accesses wait; the decision uses registered counts,
    // so a slot freed this cycle is only visible next cycle.
    assign w_data_ok    = r_write ? !w_tx_full : !w_rx_empty;
    assign w_complete   = (r_state == ST_DATA) && ((r_offset != c_reg_data) || w_data_ok);
    assign w_stall      = (r_state == ST_DATA) && !w_complete;
    assign w_timeout    = w_stall && (WAIT_MAX != 0) && (r_wait_cnt == WW'(WAIT_MAX - 1));
    assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_ERR2) || w_complete;

    assign HREADYOUT = !(w_stall || (r_state == ST_ERR1));
    assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? c_hresp_error : c_hresp_okay;

    assign w_tx_push  = w_complete && r_write && (r_offset == c_reg_data);
    assign w_tx_flush = w_complete && r_write && (r_offset == c_reg_ctrl) && HWDATA[0];
    assign w_tx_pop   = tx_valid & tx_ready;
    assign w_rx_pop   = w_complete && !r_write && (r_offset == c_reg_data);
    assign w_rx_flush = w_complete && r_write && (r_offset == c_reg_ctrl) && HWDATA[1];
    assign w_rx_push  = rx_valid & rx_ready;

    assign tx_valid = !w_tx_empty;
    assign rx_ready = !w_rx_full;

    always_comb begin
        w_status        = '0;
        w_status[0]     = w_tx_full;
        w_status[1]     = w_rx_empty;
        w_status[15:8]  = 8'(w_tx_count);
        w_status[23:16] = 8'(w_rx_count);
    end

    always_comb begin
        HRDATA = '0;
        if (w_complete && !r_write) begin
            case (r_offset)
                c_reg_data:   HRDATA = w_rx_head;
                c_reg_status: HRDATA = w_status;
                default:      HRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state    <= ST_IDLE;
            r_offset   <= '0;
            r_write    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (w_can_accept && w_accept) begin
                r_offset <= HADDR[3:2];
                r_write  <= HWRITE;
            end
            case (r_state)
                ST_IDLE, ST_ERR2: r_state <= w_addr_state;
                ST_DATA: begin
                    if (w_complete) begin
                        r_state    <= w_addr_state;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state    <= ST_ERR1;
                        r_wait_cnt <= '0;
                    end else if (WAIT_MAX != 0) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_ERR1: r_state <= ST_ERR2;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tx_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .flush (w_tx_flush),
        .wdata (HWDATA),
        .rdata (tx_data),
        .count (w_tx_count),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_rx_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .flush (w_rx_flush),
        .wdata (rx_data),
        .rdata (w_rx_head),
        .count (w_rx_count),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_ahblite_stream_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahblite_stream_port
// Description : Directed bench for ahblite_stream_port (DEPTH=8, WAIT_MAX=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahblite_stream_port;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_data;

    int checks = 0;
    int fails  = 0;

    // Single responder on the bus, so the bus-wide ready is this slave's own.
    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahblite_stream_port #(.DEPTH(8), .WAIT_MAX(4)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = a;
        HWRITE = w;
        HSIZE  = sz;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
    endtask

    // Entered and left at the negedge of a cycle in which HREADY is high.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int waits);
        addr_phase(a, w, 3'b010);
        @(negedge HCLK);
        bus_idle();
        HWDATA = wd;
        waits  = 0;
        while (HREADYOUT !== 1'b1 && waits < 64) begin
            @(negedge HCLK);
            waits++;
        end
        rd  = HRDATA;
        err = HRESP;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          waits;

        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'b010;
        HWRITE = 1'b0; HWDATA = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (2) @(negedge HCLK);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp",     32'(HRESP),     32'd0);
        chk("rst_hrdata",    HRDATA,         32'd0);
        chk("rst_tx_valid",  32'(tx_valid),  32'd0);
        chk("rst_rx_ready",  32'(rx_ready),  32'd1);
        HRESET = 1'b0;
        @(negedge HCLK);

        // Single write, then STATUS read pipelined behind it.
        xfer(32'h0, 1'b1, 32'hDEADBEEF, rd, err, waits);
        chk("wr1_waits", 32'(waits), 32'd0);
        chk("wr1_resp",  32'(err),   32'd0);
        xfer(32'h4, 1'b0, 32'h0, rd, err, waits);
        chk("status_after_wr1", rd, 32'h0000_0102);
        chk("tx_valid_1", 32'(tx_valid), 32'd1);
        chk("tx_data_1",  tx_data, 32'hDEADBEEF);

        // Fill TX to DEPTH, then a ninth write stalls.
        for (int i = 1; i < 8; i++) begin
            xfer(32'h0, 1'b1, 32'h100 + 32'(i), rd, err, waits);
        end
        xfer(32'h4, 1'b0, 32'h0, rd, err, waits);
        chk("status_tx_full", rd, 32'h0000_0803);
        addr_phase(32'h0, 1'b1, 3'b010);
        @(negedge HCLK);
        bus_idle();
        HWDATA = 32'h99;
        chk("wr9_stall1", 32'(HREADYOUT), 32'd0);
        @(negedge HCLK);
        chk("wr9_stall2", 32'(HREADYOUT), 32'd0);
        @(negedge HCLK);
        chk("wr9_stall3", 32'(HREADYOUT), 32'd0);
        tx_ready = 1'b1;
        @(negedge HCLK);
        // Pop on the previous edge frees a slot; completion follows one cycle on.
        chk("wr9_done_ready", 32'(HREADYOUT), 32'd1);
        chk("wr9_done_resp",  32'(HRESP),     32'd0);
        chk("tx_head_after_pop", tx_data, 32'h101);
        tx_ready = 1'b0;
        @(negedge HCLK);
        xfer(32'h4, 1'b0, 32'h0, rd, err, waits);
        chk("status_refull", rd, 32'h0000_0803);
        xfer(32'h8, 1'b1, 32'h3, rd, err, waits);
        xfer(32'h4, 1'b0, 32'h0, rd, err, waits);
        chk("status_flushed", rd, 32'h0000_0002);

        // Read from empty RX: four stalls, then the two-cycle ERROR.
        addr_phase(32'h0, 1'b0, 3'b010);
        @(negedge HCLK);
        bus_idle();
        for (int k = 0; k < 4; k++) begin
            chk("rd_empty_stall_ready", 32'(HREADYOUT), 32'd0);
            chk("rd_empty_stall_resp",  32'(HRESP),     32'd0);
            chk("rd_empty_stall_data",  HRDATA,         32'd0);
            @(negedge HCLK);
        end
        chk("err1_ready", 32'(HREADYOUT), 32'd0);
        chk("err1_resp",  32'(HRESP),     32'd1);
        @(negedge HCLK);
        chk("err2_ready", 32'(HREADYOUT), 32'd1);
        chk("err2_resp",  32'(HRESP),     32'd1);
        xfer(32'h4, 1'b0, 32'h0, rd, err, waits);
        chk("status_after_timeout", rd, 32'h0000_0002);

        // Halfword write, then word read of the unmapped offset 0xC.
        addr_phase(32'h0, 1'b1, 3'b001);
        @(negedge HCLK);
        bus_idle();
        HWDATA = 32'h55;
        chk("hw_err1_ready", 32'(HREADYOUT), 32'd0);
        chk("hw_err1_resp",  32'(HRESP),     32'd1);
        @(negedge HCLK);
        chk("hw_err2_ready", 32'(HREADYOUT), 32'd1);
        chk("hw_err2_resp",  32'(HRESP),     32'd1);
        addr_phase(32'hC, 1'b0, 3'b010);
        @(negedge HCLK);
        bus_idle();
        chk("c_err1_ready", 32'(HREADYOUT), 32'd0);
        chk("c_err1_resp",  32'(HRESP),     32'd1);
        @(negedge HCLK);
        chk("c_err2_ready", 32'(HREADYOUT), 32'd1);
        chk("c_err2_resp",  32'(HRESP),     32'd1);
        xfer(32'h4, 1'b0, 32'h0, rd, err, waits);
        chk("status_after_illegal", rd, 32'h0000_0002);

        // Two RX pushes, then back-to-back reads of DATA.
        rx_valid = 1'b1;
        rx_data  = 32'h11;
        @(negedge HCLK);
        rx_data  = 32'h22;
        @(negedge HCLK);
        rx_valid = 1'b0;
        addr_phase(32'h0, 1'b0, 3'b010);
        @(negedge HCLK);
        chk("rd1_ready", 32'(HREADYOUT), 32'd1);
        chk("rd1_data",  HRDATA,         32'h11);
        @(negedge HCLK);
        chk("rd2_ready", 32'(HREADYOUT), 32'd1);
        chk("rd2_data",  HRDATA,         32'h22);
        xfer(32'h4, 1'b0, 32'h0, rd, err, waits);
        chk("status_rx_drained", rd, 32'h0000_0002);

        // TX flush coinciding with a stream pop.
        for (int i = 0; i < 3; i++) begin
            xfer(32'h0, 1'b1, 32'h200 + 32'(i), rd, err, waits);
        end
        addr_phase(32'h8, 1'b1, 3'b010);
        @(negedge HCLK);
        bus_idle();
        HWDATA   = 32'h1;
        tx_ready = 1'b1;
        chk("ctrl_ready", 32'(HREADYOUT), 32'd1);
        @(negedge HCLK);
        tx_ready = 1'b0;
        chk("tx_valid_after_flush", 32'(tx_valid), 32'd0);
        xfer(32'h4, 1'b0, 32'h0, rd, err, waits);
        chk("status_after_flush", rd, 32'h0000_0002);

        // Asynchronous reset in the middle of a stalled write.
        for (int i = 0; i < 8; i++) begin
            xfer(32'h0, 1'b1, 32'h300 + 32'(i), rd, err, waits);
        end
        addr_phase(32'h0, 1'b1, 3'b010);
        @(negedge HCLK);
        bus_idle();
        HWDATA = 32'h77;
        chk("pre_rst_stall", 32'(HREADYOUT), 32'd0);
        #2;
        HRESET = 1'b1;
        #1;
        chk("async_rst_ready",    32'(HREADYOUT), 32'd1);
        chk("async_rst_resp",     32'(HRESP),     32'd0);
        chk("async_rst_tx_valid", 32'(tx_valid),  32'd0);
        chk("async_rst_rx_ready", 32'(rx_ready),  32'd1);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        xfer(32'h4, 1'b0, 32'h0, rd, err, waits);
        chk("status_after_rst", rd, 32'h0000_0002);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
